// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_types_pkg
//  Description : Shared types for the cache/memory bus. Defines the RAM
//                handshake state, the bus word, the memory arbiter FSM
//                states, the load value returned on a failed transaction,
//                and a width helper for small saturating counters.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // RAM handshake reported by the RAM model.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Memory arbiter FSM.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DSERVE = 2'd1,
        ISERVE = 2'd2
    } arbstate_t;

    // Load value handed back on an error or timeout completion.
    localparam word_t ERROR_WORD = 32'hBAD1BAD1;

    // Bits needed to hold 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_counter.sv
`default_nettype none
// ============================================================================
//  Module      : arb_counter
//  Description : Saturating up-counter with synchronous clear. Counts from 0
//                up to MAX and holds there; o_term is high while the count
//                equals MAX. Clear has priority over increment.
//  Ports       : clk     - clock
//                rst     - synchronous active-high reset (count -> 0)
//                i_clr   - clear the count to 0 at the next edge
//                i_inc   - increment (ignored once MAX is reached)
//                o_term  - count == MAX
//  Revision    : 1.0  initial release
// ============================================================================
module arb_counter
    import cpu_types_pkg::*;
#(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_term
);

    localparam int unsigned   WIDTH = cnt_width(MAX);
    localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_inc && (cnt_q != C_MAX)) begin
            cnt_d = cnt_q + C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_term = (cnt_q == C_MAX);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Memory-side responder for the cache bus. Arbitrates the
//                instruction and data requesters onto one RAM port, follows
//                the RAM handshake, and returns wait/load to the winner.
//                Data wins by default; after STARVE_MAX consecutive data
//                grants with an instruction request pending, instruction is
//                served next. A serve state that sees no ACCESS within
//                TIMEOUT cycles completes with ERR_WORD and sets err.
//  Ports       : CLK, RST            - clock, synchronous active-high reset
//                iREN, iaddr         - instruction read request / address
//                dREN, dWEN          - data read / write request
//                daddr, dstore       - data address / write value
//                iwait, dwait        - low only in the requester's completion
//                iload, dload        - returned load data (0 while waiting)
//                ramREN, ramWEN      - RAM strobes
//                ramaddr, ramstore   - RAM address / write data
//                ramload, ramstate   - RAM read data / handshake state
//                err                 - sticky error flag
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 64,
    parameter word_t       ERR_WORD   = ERROR_WORD
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        iwait,
    output logic        dwait,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    arbstate_t state_q, state_d;
    logic      op_write_q, op_write_d;
    logic      err_q, err_d;

    ramstate_t w_ram_st;
    logic      w_data_req;
    logic      w_idle;
    logic      w_serving;
    logic      w_grant_d;
    logic      w_grant_i;
    logic      w_abort;
    logic      w_access;
    logic      w_done;
    logic      w_fail_done;
    logic      w_starved;
    logic      w_tmo_term;
    word_t     w_resp;

    assign w_ram_st   = ramstate_t'(ramstate);
    assign w_data_req = dREN | dWEN;
    assign w_idle     = (state_q == IDLE);
    assign w_serving  = (state_q == DSERVE) || (state_q == ISERVE);

    // Data wins unless the instruction side has been passed over
    // STARVE_MAX times in a row while still asking.
    assign w_grant_d = w_idle && w_data_req && (!w_starved || !iREN);
    assign w_grant_i = w_idle && !w_grant_d && iREN;

    // The granted requester withdrew before completion: quietly drop it.
    assign w_abort = ((state_q == DSERVE) && !w_data_req) ||
                     ((state_q == ISERVE) && !iREN);

    // ACCESS is checked first so a real response beats a same-cycle timeout.
    assign w_access    = (w_ram_st == ACCESS);
    assign w_done      = w_serving && !w_abort &&
                         (w_access || (w_ram_st == ERROR) || w_tmo_term);
    assign w_fail_done = w_done && !w_access;
    assign w_resp      = w_access ? ramload : ERR_WORD;

    // Consecutive data grants taken while an instruction request waits.
    arb_counter #(
        .MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk    (CLK),
        .rst    (RST),
        .i_clr  (w_grant_i || (w_idle && !iREN)),
        .i_inc  (w_grant_d && iREN),
        .o_term (w_starved)
    );

    // Serve-cycle timer. Held at 0 in IDLE so it reads 0 on the first serve
    // cycle; it reaches TIMEOUT-1 on the TIMEOUT-th serve cycle.
    arb_counter #(
        .MAX (TIMEOUT - 1)
    ) u_tmo_cnt (
        .clk    (CLK),
        .rst    (RST),
        .i_clr  (w_idle),
        .i_inc  (w_serving && !w_done && !w_abort),
        .o_term (w_tmo_term)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        op_write_d = op_write_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (w_grant_d) begin
                    state_d    = DSERVE;
                    op_write_d = dWEN;          // write wins over read
                end else if (w_grant_i) begin
                    state_d    = ISERVE;
                end
            end
            DSERVE, ISERVE: begin
                if (w_abort || w_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (w_fail_done) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            op_write_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_write_q <= op_write_d;
            err_q      <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Output mux: RAM side follows the registered state, the wait/load
    // side also reacts to this cycle's ramstate.
    // ------------------------------------------------------------------
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            DSERVE: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = op_write_q;
                ramREN   = ~op_write_q;
                if (w_done) begin
                    dwait = 1'b0;
                    dload = w_resp;
                end
            end
            ISERVE: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (w_done) begin
                    iwait = 1'b0;
                    iload = w_resp;
                end
            end
            default: begin
            end
        endcase
    end

    assign err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter. Inputs change
//                1 time unit after the rising edge; outputs are sampled on
//                the falling edge and compared with hand-computed values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam logic [1:0]  RS_FREE   = 2'd0;
    localparam logic [1:0]  RS_BUSY   = 2'd1;
    localparam logic [1:0]  RS_ACCESS = 2'd2;
    localparam logic [1:0]  RS_ERROR  = 2'd3;
    localparam logic [31:0] C_BAD     = 32'hBAD1BAD1;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic [31:0] ramload = '0;
    logic [1:0]  ramstate = RS_FREE;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore;

    int n_cmp = 0;
    int n_bad = 0;

    mem_arbiter u_dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .iwait    (iwait),
        .dwait    (dwait),
        .iload    (iload),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        @(negedge CLK);
    endtask

    task automatic advance();
        @(posedge CLK);
        #1;
    endtask

    int          early;
    logic [1:0]  exp_g;

    initial begin
        // ---------------- reset ----------------
        RST = 1'b1;
        advance();
        advance();
        sample();
        check("rst_iwait",    32'(iwait),  1);
        check("rst_dwait",    32'(dwait),  1);
        check("rst_ramREN",   32'(ramREN), 0);
        check("rst_ramWEN",   32'(ramWEN), 0);
        check("rst_ramaddr",  ramaddr,     0);
        check("rst_ramstore", ramstore,    0);
        check("rst_iload",    iload,       0);
        check("rst_dload",    dload,       0);
        check("rst_err",      32'(err),    0);
        advance();
        RST = 1'b0;

        // ---------------- single instruction read ----------------
        iREN = 1'b1; iaddr = 32'h40; ramstate = RS_FREE;
        sample();
        check("rd_idle_ramREN", 32'(ramREN), 0);
        check("rd_idle_iwait",  32'(iwait),  1);
        advance(); ramstate = RS_BUSY;
        sample();
        check("rd_ramREN",  32'(ramREN), 1);
        check("rd_ramaddr", ramaddr,     32'h40);
        check("rd_busy1_iwait", 32'(iwait), 1);
        check("rd_busy1_iload", iload, 0);
        advance();
        sample();
        check("rd_busy2_iwait", 32'(iwait), 1);
        advance(); ramstate = RS_ACCESS; ramload = 32'h8C010004;
        sample();
        check("rd_acc_iwait", 32'(iwait), 0);
        check("rd_acc_iload", iload, 32'h8C010004);
        check("rd_acc_dwait", 32'(dwait), 1);
        advance(); iREN = 1'b0; ramstate = RS_FREE; ramload = '0;
        sample();
        check("rd_done_iwait",  32'(iwait),  1);
        check("rd_done_ramREN", 32'(ramREN), 0);
        check("rd_done_ramaddr", ramaddr, 0);
        advance();

        // ---------------- simultaneous requests ----------------
        iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h1234;
        sample();
        check("sim_idle_ramWEN", 32'(ramWEN), 0);
        advance(); ramstate = RS_ACCESS;
        sample();
        check("sim_d_ramWEN",   32'(ramWEN), 1);
        check("sim_d_ramREN",   32'(ramREN), 0);
        check("sim_d_ramstore", ramstore,    32'h1234);
        check("sim_d_ramaddr",  ramaddr,     32'h80);
        check("sim_d_dwait",    32'(dwait),  0);
        check("sim_d_iwait",    32'(iwait),  1);
        advance(); dWEN = 1'b0; ramstate = RS_FREE;
        sample();
        check("sim_gap_iwait",  32'(iwait),  1);
        check("sim_gap_dwait",  32'(dwait),  1);
        check("sim_gap_ramREN", 32'(ramREN), 0);
        advance(); ramstate = RS_BUSY;
        sample();
        check("sim_i_ramREN",  32'(ramREN), 1);
        check("sim_i_ramaddr", ramaddr,     32'h44);
        check("sim_i_busy_iwait", 32'(iwait), 1);
        advance(); ramstate = RS_ACCESS; ramload = 32'h11112222;
        sample();
        check("sim_i_iwait", 32'(iwait), 0);
        check("sim_i_iload", iload, 32'h11112222);
        advance(); iREN = 1'b0; ramstate = RS_FREE; ramload = '0;
        sample();
        advance();

        // ---------------- starvation ----------------
        // Expected grant order with both held: D D D D I D D
        iREN = 1'b1; dREN = 1'b1; iaddr = 32'h48; daddr = 32'h90;
        for (int g = 0; g < 7; g++) begin
            ramstate = RS_FREE;
            sample();
            advance();
            ramstate = RS_ACCESS; ramload = 32'(g);
            sample();
            exp_g = (g == 4) ? 2'b01 : 2'b10;   // {iwait,dwait}
            check($sformatf("starve_grant%0d", g), 32'({iwait, dwait}), 32'(exp_g));
            advance();
        end
        iREN = 1'b0; dREN = 1'b0; ramstate = RS_FREE; ramload = '0;
        sample();
        advance();

        // ---------------- abort ----------------
        iREN = 1'b1; iaddr = 32'h50;
        sample();
        advance(); ramstate = RS_BUSY;
        sample();
        check("abt_ramREN", 32'(ramREN), 1);
        advance(); iREN = 1'b0;
        sample();
        check("abt_nopulse_iwait", 32'(iwait), 1);
        check("abt_nopulse_iload", iload, 0);
        advance(); ramstate = RS_FREE;
        sample();
        check("abt_idle_ramREN", 32'(ramREN), 0);
        check("abt_err", 32'(err), 0);
        advance();

        // ---------------- RAM error on data read ----------------
        dREN = 1'b1; daddr = 32'h100;
        sample();
        advance(); ramstate = RS_ERROR;
        sample();
        check("erd_ramREN", 32'(ramREN), 1);
        check("erd_dwait",  32'(dwait),  0);
        check("erd_dload",  dload,       C_BAD);
        check("erd_iwait",  32'(iwait),  1);
        advance(); dREN = 1'b0; ramstate = RS_FREE;
        sample();
        check("erd_err",   32'(err),   1);
        check("erd_dload_idle", dload, 0);
        advance();

        // ---------------- timeout on instruction read ----------------
        iREN = 1'b1; iaddr = 32'h60;
        sample();
        advance(); ramstate = RS_BUSY;
        early = 0;
        for (int c = 1; c <= 63; c++) begin
            sample();
            if (iwait !== 1'b1) early++;
            advance();
        end
        check("tmo_no_early", 32'(early), 0);
        sample();
        check("tmo_iwait", 32'(iwait), 0);
        check("tmo_iload", iload, C_BAD);
        advance(); iREN = 1'b0; ramstate = RS_FREE;
        sample();
        check("tmo_err_sticky", 32'(err),    1);
        check("tmo_idle_ramREN", 32'(ramREN), 0);
        advance();

        // ---------------- reset mid-DSERVE ----------------
        dWEN = 1'b1; daddr = 32'h200; dstore = 32'hCAFE;
        sample();
        advance(); ramstate = RS_BUSY;
        sample();
        check("mrst_ramWEN", 32'(ramWEN), 1);
        check("mrst_ramaddr", ramaddr, 32'h200);
        advance(); RST = 1'b1;
        sample();
        advance(); dWEN = 1'b0;
        sample();
        check("mrst_after_ramWEN",   32'(ramWEN), 0);
        check("mrst_after_ramREN",   32'(ramREN), 0);
        check("mrst_after_ramaddr",  ramaddr,     0);
        check("mrst_after_ramstore", ramstore,    0);
        check("mrst_after_dwait",    32'(dwait),  1);
        check("mrst_after_iwait",    32'(iwait),  1);
        check("mrst_after_dload",    dload,       0);
        check("mrst_after_err",      32'(err),    0);
        RST = 1'b0; ramstate = RS_FREE;
        advance();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Memory-side responder for the cache bus: accepts icache requests (iREN/iaddr) and dcache requests (dREN/dWEN/daddr/dstore) and answers with iwait/dwait plus iload/dload.
- Arbitrates both requesters onto a single RAM port and tracks the RAM handshake through ramstate.
- Sits between the caches block and the RAM model, closing the path datapath -> caches -> memory.

Parameters:
- STARVE_MAX, 4: consecutive data grants allowed while iREN is pending; after that, the next grant goes to instruction.
- TIMEOUT, 64: cycles a serve state may wait for ACCESS before the transaction is aborted with an error.
- ERR_WORD, 32'hBAD1BAD1: load value returned on an error or timeout completion.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction word address.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  32  data word address.
- dstore  in  32  data write value.
- iwait  out  1  0 only in the instruction completion cycle.
- dwait  out  1  0 only in the data completion cycle.
- iload  out  32  instruction read data.
- dload  out  32  data read data.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- err  out  1  sticky error flag.

Behaviour:
- Reset (RST=1 at an edge):
  - state=IDLE; starve_cnt=0; tmo_cnt=0; err=0.
  - Outputs while in IDLE: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
  - Reset mid-transaction drops the request immediately; no wait pulse is produced.
- FSM states: IDLE, DSERVE, ISERVE.
- IDLE: grant decided combinationally, state registered, so RAM strobes assert the cycle after the request is first seen.
  - Data request (dREN|dWEN) present and (starve_cnt<STARVE_MAX or iREN=0) -> DSERVE.
  - Otherwise, if iREN -> ISERVE.
  - Otherwise stay in IDLE.
- Latched command:
  - On entering DSERVE, latch op: write if dWEN, else read. dWEN has priority when dREN&dWEN.
  - Address and store data are driven live from daddr/dstore (and iaddr in ISERVE). The requester holds them stable until wait=0.
- DSERVE drives:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=op_write, ramREN=~op_write.
- ISERVE drives: ramaddr=iaddr, ramREN=1.
- Completion, in the serve state:
  - ramstate==ACCESS: the granted wait=0 combinationally that cycle; iload or dload=ramload (dload value is don't-care on a write). Next state IDLE.
  - ramstate==ERROR, or tmo_cnt==TIMEOUT-1: wait=0 that cycle, load=ERROR_WORD, err<=1 (sticky until RST), next state IDLE.
  - The non-granted wait stays 1 throughout.
- Abort: the granted requester deasserts its request before completion -> next IDLE, no wait pulse, no err.
- starve_cnt:
  - Increments on each DSERVE entry while iREN=1, saturating at STARVE_MAX.
  - Clears on ISERVE entry, or in IDLE when iREN=0.
- tmo_cnt: clears on serve entry, increments each serve cycle without completion.
- Back-to-back: there is always at least one IDLE cycle between transactions, so the minimum transaction is 3 cycles: IDLE grant, serve with ACCESS, IDLE.
- Outputs: iload and dload are 0 whenever their wait=1. RAM strobes are 0 in IDLE.

Decomposition:
- cpu_types_pkg:
  - ramstate_t, word_t.
  - New arbstate_t enum {IDLE, DSERVE, ISERVE}.
  - ERROR_WORD constant.
- Sub-module arb_counter: saturating counter with clear, increment, max, and a terminal flag. It is instanced twice, for starve_cnt and tmo_cnt.
- Top level: FSM plus output mux.

Test Plan:
- Single read:
  - Stimulus: iREN=1, iaddr=0x40; RAM gives BUSY 2 cycles then ACCESS with ramload=0x8C010004.
  - Required: ramREN rises 1 cycle after iREN, ramaddr=0x40, iwait=0 for exactly the ACCESS cycle, iload=0x8C010004, FSM back to IDLE.
- Simultaneous requests:
  - Stimulus: iREN=1 and dWEN=1 in the same cycle, daddr=0x80, dstore=0x1234.
  - Required: data served first (ramWEN=1, ramstore=0x1234), dwait pulses, then ISERVE; iwait=1 until its own ACCESS.
- Starvation:
  - Stimulus: dREN held for 6 requests while iREN held.
  - Required: after 4 data grants the 5th grant is ISERVE, then data resumes.
- Error and timeout:
  - Stimulus: ramstate=ERROR during DSERVE read.
  - Required: dwait=0, dload=0xBAD1BAD1, err=1 and stays 1.
  - Stimulus: separately, ramstate stuck at BUSY.
  - Required: completion forced on the 64th serve cycle with the same response.
- Abort and reset:
  - Stimulus: iREN dropped mid-ISERVE.
  - Required: IDLE next cycle, no iwait pulse.
  - Stimulus: RST=1 mid-DSERVE.
  - Required: all outputs return to their reset values at the next edge, err=0.
